// File: rtl/popcount_rr_scheduler.sv
// Round-robin scheduler sharing one serial popcount engine among REQ_N requesters.
// A granted word is counted one bit per clock, and the result is returned tagged with its requester id.
module popcount_rr_scheduler #(
    parameter  int WIDTH = 7,
    parameter  int REQ_N = 4,
    localparam int CW    = $clog2(WIDTH) + 1,
    localparam int IW    = $clog2(REQ_N)
) (
    input  logic                   clk_i,
    input  logic                   srst_i,
    input  logic [REQ_N*WIDTH-1:0] req_data_i,
    input  logic [REQ_N-1:0]       req_val_i,
    output logic [REQ_N-1:0]       req_ready_o,
    output logic [CW-1:0]          data_o,
    output logic [IW-1:0]          id_o,
    output logic                   data_val_o,
    output logic                   busy_o
);
    localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [WIDTH-1:0]  word_q, word_d;
    logic [IW-1:0]     id_q, id_d;
    logic [CW-1:0]     acc_q, acc_d;
    logic [XW-1:0]     idx_q, idx_d;
    logic [CW-1:0]     data_q, data_d;
    logic [IW-1:0]     res_id_q, res_id_d;

    logic              found;
    logic [IW-1:0]     grant_id;
    logic [WIDTH-1:0]  grant_word;

    // Arbiter: first valid requester scanning ptr, ptr+1, ... with wrap at REQ_N.
    always_comb begin
        logic [IW:0]   sum;
        logic [IW-1:0] cand;
        found      = 1'b0;
        grant_id   = '0;
        grant_word = '0;
        sum        = '0;
        cand       = '0;
        for (int i = 0; i < REQ_N; i++) begin
            sum = {1'b0, ptr_q} + (IW+1)'(i);
            if (sum >= (IW+1)'(REQ_N)) sum = sum - (IW+1)'(REQ_N);
            cand = sum[IW-1:0];
            if (!found && req_val_i[cand]) begin
                found      = 1'b1;
                grant_id   = cand;
                grant_word = req_data_i[int'(cand)*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (srst_i) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            word_q   <= '0;
            id_q     <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            res_id_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            word_q   <= word_d;
            id_q     <= id_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            res_id_q <= res_id_d;
        end
    end

    always_comb begin
        // NOTE: every variable gets a hold default first so no path infers a latch.
        state_d  = state_q;
        ptr_d    = ptr_q;
        word_d   = word_q;
        id_d     = id_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        data_d   = data_q;
        res_id_d = res_id_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = COUNT;
                    word_d  = grant_word;
                    id_d    = grant_id;
                    acc_d   = '0;
                    idx_d   = '0;
                    ptr_d   = (grant_id == IW'(REQ_N-1)) ? '0 : grant_id + 1'b1;
                end
            end
            COUNT: begin
                acc_d = acc_q + CW'(word_q[idx_q]);
                idx_d = idx_q + 1'b1;
                // The result registers load on the last bit so they are valid throughout DONE.
                if (idx_q == XW'(WIDTH-1)) begin
                    state_d  = DONE;
                    data_d   = acc_d;
                    res_id_d = id_q;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = '0;
        if (state_q == IDLE && found) req_ready_o = {{(REQ_N-1){1'b0}}, 1'b1} << grant_id;
        data_val_o  = (state_q == DONE);
        busy_o      = (state_q != IDLE);
        data_o      = data_q;
        id_o        = res_id_q;
    end
endmodule

// File: tb/tb_popcount_rr_scheduler.sv
// Directed bench for popcount_rr_scheduler: arbitration order, latency, result tagging and reset abort.
module tb_popcount_rr_scheduler;
    localparam int WIDTH = 7;
    localparam int REQ_N = 4;
    localparam int CW    = $clog2(WIDTH) + 1;
    localparam int IW    = $clog2(REQ_N);

    logic                   clk = 1'b0;
    logic                   srst = 1'b0;
    logic [REQ_N*WIDTH-1:0] req_data = '0;
    logic [REQ_N-1:0]       req_val = '0;
    logic [REQ_N-1:0]       req_ready;
    logic [CW-1:0]          data;
    logic [IW-1:0]          id;
    logic                   data_val;
    logic                   busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    popcount_rr_scheduler #(.WIDTH(WIDTH), .REQ_N(REQ_N)) dut (
        .clk_i       (clk),
        .srst_i      (srst),
        .req_data_i  (req_data),
        .req_val_i   (req_val),
        .req_ready_o (req_ready),
        .data_o      (data),
        .id_o        (id),
        .data_val_o  (data_val),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        srst = 1'b1;
        tick();
        srst = 1'b0;
    endtask

    // Returns the cycle number of the next strobe, or -1 after 30 cycles without one.
    task automatic wait_strobe(output int t);
        int n = 0;
        while (data_val !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        t = (data_val === 1'b1) ? cyc : -1;
    endtask

    task automatic test_reset();
        do_reset();
        do_reset();
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b required 0000", req_ready); end
        checks++; if (data !== 4'd0) begin errors++; $display("FAIL reset_data: got %0d required 0", data); end
        checks++; if (id !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d required 0", id); end
        checks++; if (data_val !== 1'b0) begin errors++; $display("FAIL reset_val: got %b required 0", data_val); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    endtask

    task automatic test_full_word();
        int hs, t;
        req_data[0*WIDTH +: WIDTH] = 7'b1111111;
        req_val = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL full_ready: got %b required 0001", req_ready); end
        hs = cyc;
        tick();
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL full_ready_count: got %b required 0000", req_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy: got %b required 1", busy); end
        req_val = 4'b0000;
        wait_strobe(t);
        checks++; if (t - hs !== 8) begin errors++; $display("FAIL full_latency: got %0d required 8", t - hs); end
        checks++; if (data !== 4'd7) begin errors++; $display("FAIL full_data: got %0d required 7", data); end
        checks++; if (id !== 2'd0) begin errors++; $display("FAIL full_id: got %0d required 0", id); end
        tick();
    endtask

    task automatic test_back_to_back();
        int hs, t1, t2;
        req_data[2*WIDTH +: WIDTH] = 7'b0000000;
        req_val = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL b2b_ready1: got %b required 0100", req_ready); end
        hs = cyc;
        tick();
        req_data[2*WIDTH +: WIDTH] = 7'b1010101;
        wait_strobe(t1);
        checks++; if (t1 - hs !== 8) begin errors++; $display("FAIL b2b_latency: got %0d required 8", t1 - hs); end
        checks++; if (data !== 4'd0 || id !== 2'd2) begin errors++; $display("FAIL b2b_res1: got data=%0d id=%0d required data=0 id=2", data, id); end
        tick();
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL b2b_ready2: got %b required 0100", req_ready); end
        tick();
        req_val = 4'b0000;
        wait_strobe(t2);
        checks++; if (t2 - t1 !== 9) begin errors++; $display("FAIL b2b_spacing: got %0d required 9", t2 - t1); end
        checks++; if (data !== 4'd4 || id !== 2'd2) begin errors++; $display("FAIL b2b_res2: got data=%0d id=%0d required data=4 id=2", data, id); end
        tick();
    endtask

    task automatic test_all_requesters();
        int exp_order[6] = '{0, 1, 2, 3, 0, 1};
        int t, t_prev;
        logic [REQ_N-1:0] exp_ready;
        do_reset();
        req_data[0*WIDTH +: WIDTH] = 7'b0000011;
        req_data[1*WIDTH +: WIDTH] = 7'b0000111;
        req_data[2*WIDTH +: WIDTH] = 7'b0001111;
        req_data[3*WIDTH +: WIDTH] = 7'b0011111;
        req_val = 4'b1111;
        t_prev = -1;
        for (int g = 0; g < 6; g++) begin
            #1;
            exp_ready = 4'b0001 << exp_order[g];
            checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL all_grant%0d: got %b required %b", g, req_ready, exp_ready); end
            tick();
            wait_strobe(t);
            checks++; if (id !== IW'(exp_order[g]) || data !== CW'(exp_order[g] + 2)) begin
                errors++; $display("FAIL all_res%0d: got data=%0d id=%0d required data=%0d id=%0d", g, data, id, exp_order[g] + 2, exp_order[g]);
            end
            if (g > 0) begin
                checks++; if (t - t_prev !== 9) begin errors++; $display("FAIL all_spacing%0d: got %0d required 9", g, t - t_prev); end
            end
            t_prev = t;
            tick();
        end
        req_val = 4'b0000;
    endtask

    task automatic test_pointer();
        int t, multi;
        multi = 0;
        req_val = 4'b1010;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL ptr_first: got %b required 1000", req_ready); end
        tick();
        req_val = 4'b0010;
        wait_strobe(t);
        checks++; if (id !== 2'd3 || data !== 4'd5) begin errors++; $display("FAIL ptr_res1: got data=%0d id=%0d required data=5 id=3", data, id); end
        tick();
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL ptr_second: got %b required 0010", req_ready); end
        tick();
        req_val = 4'b0000;
        for (int n = 0; n < 12 && data_val !== 1'b1; n++) begin
            if ($countones(req_ready) > 1) multi++;
            tick();
        end
        checks++; if (id !== 2'd1 || data !== 4'd3 || data_val !== 1'b1) begin
            errors++; $display("FAIL ptr_res2: got data=%0d id=%0d val=%b required data=3 id=1 val=1", data, id, data_val);
        end
        checks++; if (multi !== 0) begin errors++; $display("FAIL ptr_onehot: got %0d multi-bit cycles required 0", multi); end
        tick();
    endtask

    task automatic test_srst_mid_count();
        int hs, t;
        req_data[0*WIDTH +: WIDTH] = 7'b1111111;
        req_val = 4'b0001;
        tick();
        req_val = 4'b0000;
        repeat (3) tick();
        srst = 1'b1;
        tick();
        srst = 1'b0;
        checks++; if (busy !== 1'b0 || data_val !== 1'b0) begin errors++; $display("FAIL srst_ctrl: got busy=%b val=%b required 0 0", busy, data_val); end
        checks++; if (data !== 4'd0 || id !== 2'd0) begin errors++; $display("FAIL srst_out: got data=%0d id=%0d required 0 0", data, id); end
        req_val = 4'b1010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL srst_ptr: got %b required 0010", req_ready); end
        req_data[0*WIDTH +: WIDTH] = 7'b0000011;
        req_val = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL srst_accept: got %b required 0001", req_ready); end
        hs = cyc;
        tick();
        req_val = 4'b0000;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL srst_busy: got %b required 1", busy); end
        wait_strobe(t);
        checks++; if (t - hs !== 8) begin errors++; $display("FAIL srst_no_stale: got strobe after %0d required 8", t - hs); end
        checks++; if (data !== 4'd2 || id !== 2'd0) begin errors++; $display("FAIL srst_res: got data=%0d id=%0d required data=2 id=0", data, id); end
        tick();
    endtask

    task automatic test_rehold();
        int t1, t2;
        req_data[0*WIDTH +: WIDTH] = 7'b0000001;
        req_val = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL hold_ready1: got %b required 0001", req_ready); end
        tick();
        wait_strobe(t1);
        checks++; if (data !== 4'd1 || id !== 2'd0) begin errors++; $display("FAIL hold_res1: got data=%0d id=%0d required data=1 id=0", data, id); end
        tick();
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL hold_regrant: got %b required 0001", req_ready); end
        tick();
        req_val = 4'b0000;
        repeat (3) tick();
        checks++; if (data !== 4'd1 || data_val !== 1'b0) begin errors++; $display("FAIL hold_between: got data=%0d val=%b required data=1 val=0", data, data_val); end
        wait_strobe(t2);
        checks++; if (t2 - t1 !== 9) begin errors++; $display("FAIL hold_spacing: got %0d required 9", t2 - t1); end
        checks++; if (data !== 4'd1) begin errors++; $display("FAIL hold_res2: got %0d required 1", data); end
        tick();
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_back_to_back();
        test_all_requesters();
        test_pointer();
        test_srst_mid_count();
        test_rehold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
